// File: rtl/vga_ball_renderer.sv
// vga_ball_renderer
// Pixel-colour stage that sits directly after hvsync_generator. It registers
// a 3-bit colour per pixel clock, giving one cycle of latency. It also owns a
// square ball that steps once per frame during vertical blanking and bounces
// off the edges of the active area.
//
// Ports:
//   clk           pixel clock, shared with hvsync_generator
//   reset         synchronous, active-high; has priority over everything
//   CounterX/Y    current raster position from hvsync_generator
//   inDisplayArea active-video flag from hvsync_generator
//   pause         level; while high, frame ticks are ignored and the ball stays put
//   pixel         registered colour to the VGA DAC pins
//   ball_x/ball_y current top-left corner of the ball
//   bounce_count  number of edge bounces, wraps from 255 to 0
//   update_done   one-cycle pulse after a per-frame position update
module vga_ball_renderer #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned BALL_SIZE    = 16,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned BORDER       = 4,
  parameter int unsigned INIT_X       = 312,
  parameter int unsigned INIT_Y       = 232,
  parameter logic [2:0]  BALL_COLOR   = 3'b100,
  parameter logic [2:0]  BORDER_COLOR = 3'b010,
  parameter logic [2:0]  BG_COLOR     = 3'b001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] CounterX,
  input  logic [9:0] CounterY,
  input  logic       inDisplayArea,
  input  logic       pause,
  output logic [2:0] pixel,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [7:0] bounce_count,
  output logic       update_done
);

  localparam logic [10:0] XMAX      = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] YMAX      = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] STEP      = 11'(SPEED);
  localparam logic [10:0] SIZE      = 11'(BALL_SIZE);
  localparam logic [10:0] BRD_LO    = 11'(BORDER);
  localparam logic [10:0] BRD_HI_X  = 11'(H_ACTIVE - BORDER);
  localparam logic [10:0] BRD_HI_Y  = 11'(V_ACTIVE - BORDER);
  localparam logic [9:0]  TICK_LINE = 10'(V_ACTIVE);

  typedef enum logic [1:0] {StWaitFrame, StUpdateX, StUpdateY} state_t;

  state_t      r_state, w_state_d;
  logic [9:0]  r_ball_x, w_ball_x_d;
  logic [9:0]  r_ball_y, w_ball_y_d;
  logic        r_dx_pos, w_dx_pos_d;  // 1: moving right
  logic        r_dy_pos, w_dy_pos_d;  // 1: moving down
  logic [7:0]  r_bounce, w_bounce_d;
  logic        r_done, w_done_d;
  logic [2:0]  r_pixel, w_pixel_d;

  // Widened copies so that ball edge + size never wraps.
  logic [10:0] w_cx, w_cy, w_bx, w_by;
  logic        w_frame_tick, w_in_ball, w_in_border;

  assign w_cx = {1'b0, CounterX};
  assign w_cy = {1'b0, CounterY};
  assign w_bx = {1'b0, r_ball_x};
  assign w_by = {1'b0, r_ball_y};

  // First pixel of vertical blanking: moving the ball here avoids tearing.
  assign w_frame_tick = (CounterX == 10'd0) && (CounterY == TICK_LINE);

  assign w_in_ball = (w_cx >= w_bx) && (w_cx < w_bx + SIZE) &&
                     (w_cy >= w_by) && (w_cy < w_by + SIZE);

  assign w_in_border = (w_cx < BRD_LO) || (w_cx >= BRD_HI_X) ||
                       (w_cy < BRD_LO) || (w_cy >= BRD_HI_Y);

  always_comb begin
    w_pixel_d = BG_COLOR;
    if (!inDisplayArea) begin
      w_pixel_d = 3'b000;
    end else if (w_in_ball) begin
      w_pixel_d = BALL_COLOR;
    end else if (w_in_border) begin
      w_pixel_d = BORDER_COLOR;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_ball_x_d = r_ball_x;
    w_ball_y_d = r_ball_y;
    w_dx_pos_d = r_dx_pos;
    w_dy_pos_d = r_dy_pos;
    w_bounce_d = r_bounce;
    w_done_d   = 1'b0;
    unique case (r_state)
      StWaitFrame: begin
        if (w_frame_tick && !pause) begin
          w_state_d = StUpdateX;
        end
      end
      StUpdateX: begin
        if (r_dx_pos) begin
          if (w_bx + STEP >= XMAX) begin
            w_ball_x_d = XMAX[9:0];
            w_dx_pos_d = 1'b0;
            w_bounce_d = r_bounce + 8'd1;
          end else begin
            w_ball_x_d = r_ball_x + STEP[9:0];
          end
        end else begin
          if (w_bx <= STEP) begin
            w_ball_x_d = 10'd0;
            w_dx_pos_d = 1'b1;
            w_bounce_d = r_bounce + 8'd1;
          end else begin
            w_ball_x_d = r_ball_x - STEP[9:0];
          end
        end
        w_state_d = StUpdateY;
      end
      StUpdateY: begin
        if (r_dy_pos) begin
          if (w_by + STEP >= YMAX) begin
            w_ball_y_d = YMAX[9:0];
            w_dy_pos_d = 1'b0;
            w_bounce_d = r_bounce + 8'd1;
          end else begin
            w_ball_y_d = r_ball_y + STEP[9:0];
          end
        end else begin
          if (w_by <= STEP) begin
            w_ball_y_d = 10'd0;
            w_dy_pos_d = 1'b1;
            w_bounce_d = r_bounce + 8'd1;
          end else begin
            w_ball_y_d = r_ball_y - STEP[9:0];
          end
        end
        w_done_d  = 1'b1;
        w_state_d = StWaitFrame;
      end
      default: begin
        w_state_d = StWaitFrame;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StWaitFrame;
      r_ball_x <= 10'(INIT_X);
      r_ball_y <= 10'(INIT_Y);
      r_dx_pos <= 1'b1;
      r_dy_pos <= 1'b1;
      r_bounce <= 8'd0;
      r_done   <= 1'b0;
      r_pixel  <= 3'b000;
    end else begin
      r_state  <= w_state_d;
      r_ball_x <= w_ball_x_d;
      r_ball_y <= w_ball_y_d;
      r_dx_pos <= w_dx_pos_d;
      r_dy_pos <= w_dy_pos_d;
      r_bounce <= w_bounce_d;
      r_done   <= w_done_d;
      r_pixel  <= w_pixel_d;
    end
  end

  assign pixel        = r_pixel;
  assign ball_x       = r_ball_x;
  assign ball_y       = r_ball_y;
  assign bounce_count = r_bounce;
  assign update_done  = r_done;

endmodule
